// File: rtl/uart_pkg.sv
// ==== uart_pkg : shared UART frame constants, rx state encoding, width helper ====
// ==== rev 1.0                                                                  ====
`default_nettype none

`ifndef CLKRATE
`define CLKRATE 1000000
`endif
`ifndef BAUD
`define BAUD 9600
`endif
`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = `CLKRATE / `BAUD;
  localparam int WORD_LENGTH_DEF  = `WORD_LENGTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ==== uart_sync2 : WIDTH-bit two-flop synchroniser with configurable reset value ====
// ==== rev 1.0                                                                    ====
`default_nettype none

module uart_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ==== uart_rx : 8N1-style UART receiver with valid/ready output, framing/overrun flags ====
// ==== rev 1.0                                                                          ====
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int WORD_LENGTH  = WORD_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   UART_Rx_IN,
  output logic [WORD_LENGTH-1:0] Rx_DATA,
  output logic                   Rx_VALID,
  input  logic                   Rx_READY,
  output logic                   Rx_FRAME_ERR,
  output logic                   Rx_OVERRUN,
  output logic                   Rx_BUSY
);

  localparam int BW = clog2_min1(CLKS_PER_BIT);
  localparam int IW = clog2_min1(WORD_LENGTH);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WORD_LENGTH - 1);

  logic                   rx_s;
  uart_rx_state_e         state;
  logic [BW-1:0]          bit_cnt;
  logic [IW-1:0]          data_idx;
  logic [WORD_LENGTH-1:0] shreg;
  logic                   done;

  uart_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rstb),
    .d     (UART_Rx_IN),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      data_idx     <= '0;
      shreg        <= '0;
      done         <= 1'b0;
      Rx_FRAME_ERR <= 1'b0;
    end else begin
      done         <= 1'b0;
      Rx_FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          data_idx <= '0;
          if (!rx_s) state <= START;
        end
        // Half-bit wait re-centres every later sample on mid-bit.
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt         <= '0;
            shreg[data_idx] <= rx_s;
            if (data_idx == IDX_LAST) begin
              data_idx <= '0;
              state    <= STOP;
            end else begin
              data_idx <= data_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              Rx_FRAME_ERR <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        // Hold off until the line recovers so a long low is not seen as a new start.
        BREAK: begin
          bit_cnt  <= '0;
          data_idx <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      Rx_DATA    <= '0;
      Rx_VALID   <= 1'b0;
      Rx_OVERRUN <= 1'b0;
    end else begin
      Rx_OVERRUN <= 1'b0;
      if (done) begin
        if (!Rx_VALID || Rx_READY) begin
          Rx_DATA  <= shreg;
          Rx_VALID <= 1'b1;
        end else begin
          Rx_OVERRUN <= 1'b1;
        end
      end else if (Rx_VALID && Rx_READY) begin
        Rx_VALID <= 1'b0;
      end
    end
  end

  assign Rx_BUSY = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ==== tb_uart_rx : directed vector bench for uart_rx ====
// ==== rev 1.0                                         ====
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 104;
  localparam int WL  = 8;
  // Line-drive edge to Rx_VALID rise: 2 sync flops + IDLE detect edge, half bit,
  // WL data bits + stop bit, then one cycle into the output register.
  localparam int LAT = 3 + CPB / 2 + (WL + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          UART_Rx_IN = 1'b1;
  logic          Rx_READY = 1'b0;
  logic [WL-1:0] Rx_DATA;
  logic          Rx_VALID;
  logic          Rx_FRAME_ERR;
  logic          Rx_OVERRUN;
  logic          Rx_BUSY;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .WORD_LENGTH  (WL)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .UART_Rx_IN   (UART_Rx_IN),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_READY     (Rx_READY),
    .Rx_FRAME_ERR (Rx_FRAME_ERR),
    .Rx_OVERRUN   (Rx_OVERRUN),
    .Rx_BUSY      (Rx_BUSY)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int            n_ferr = 0, n_ovr = 0, n_both = 0, n_vcyc = 0, n_busy_rise = 0;
  logic          prev_v = 1'b0, prev_b = 1'b0;
  logic [WL-1:0] data_q[$];
  int            rise_q[$];

  always @(negedge clk) begin
    if (Rx_VALID && !prev_v) begin
      data_q.push_back(Rx_DATA);
      rise_q.push_back(cyc);
    end
    if (Rx_VALID) n_vcyc++;
    if (Rx_BUSY && !prev_b) n_busy_rise++;
    if (Rx_FRAME_ERR) n_ferr++;
    if (Rx_OVERRUN) n_ovr++;
    if (Rx_FRAME_ERR && Rx_OVERRUN) n_both++;
    prev_v = Rx_VALID;
    prev_b = Rx_BUSY;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [WL-1:0] data, output int start);
    start = cyc;
    UART_Rx_IN = 1'b0;
    wait_bits(1);
    for (int k = 0; k < WL; k++) begin
      UART_Rx_IN = data[k];
      wait_bits(1);
    end
  endtask

  task automatic send_frame(input logic [WL-1:0] data, input logic stop, input int hold,
                            output int start);
    send_head(data, start);
    UART_Rx_IN = stop;
    wait_bits(1 + hold);
    UART_Rx_IN = 1'b1;
  endtask

  typedef struct {
    logic [WL-1:0] data;
    logic          stop;
    int            hold;
    int            exp_valid;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int start, q0, v0, f0, o0, b0;

    vecs[0] = '{8'h56, 1'b1, 0, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0};
    vecs[3] = '{8'h81, 1'b1, 0, 1, 0};
    vecs[4] = '{8'h3C, 1'b1, 0, 1, 0};
    vecs[5] = '{8'hA5, 1'b0, 0, 0, 1};

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", Rx_VALID, 0);
    check("rst_data", Rx_DATA, 0);
    check("rst_busy", Rx_BUSY, 0);
    check("rst_ferr", Rx_FRAME_ERR, 0);
    check("rst_ovr", Rx_OVERRUN, 0);
    rstb = 1'b1;

    // Idle line
    wait_bits(20);
    check("idle_valid", Rx_VALID, 0);
    check("idle_busy", Rx_BUSY, 0);
    check("idle_busy_rise", n_busy_rise, 0);
    check("idle_ferr", n_ferr, 0);
    check("idle_ovr", n_ovr, 0);

    // Table of single frames, consumer always ready
    Rx_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q0 = data_q.size();
      v0 = n_vcyc;
      f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold, start);
      wait_bits(2);
      check("vec_valid_rises", data_q.size() - q0, vecs[i].exp_valid);
      check("vec_valid_cycles", n_vcyc - v0, vecs[i].exp_valid);
      check("vec_ferr", n_ferr - f0, vecs[i].exp_ferr);
      if (data_q.size() > q0) begin
        check("vec_data", data_q[q0], vecs[i].data);
        check("vec_latency", rise_q[q0] - start, LAT);
      end
    end
    check("vec_final_busy", Rx_BUSY, 0);

    // Short low glitch on an idle line
    q0 = data_q.size();
    f0 = n_ferr;
    b0 = n_busy_rise;
    UART_Rx_IN = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    UART_Rx_IN = 1'b1;
    wait_bits(2);
    check("glitch_busy_rise", n_busy_rise - b0, 1);
    check("glitch_busy", Rx_BUSY, 0);
    check("glitch_valid", data_q.size() - q0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Bad stop bit followed by a held-low line
    q0 = data_q.size();
    f0 = n_ferr;
    send_head(8'hA5, start);
    UART_Rx_IN = 1'b0;
    wait_bits(3);
    check("brk_busy_low", Rx_BUSY, 1);
    check("brk_ferr", n_ferr - f0, 1);
    UART_Rx_IN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("brk_busy_released", Rx_BUSY, 0);
    check("brk_valid", data_q.size() - q0, 0);
    wait_bits(1);

    // Back-to-back frames with the consumer stalled
    Rx_READY = 1'b0;
    q0 = data_q.size();
    o0 = n_ovr;
    f0 = n_ferr;
    send_frame(8'h01, 1'b1, 0, start);
    send_frame(8'hFF, 1'b1, 0, start);
    wait_bits(2);
    check("ovr_valid", Rx_VALID, 1);
    check("ovr_data", Rx_DATA, 8'h01);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_rises", data_q.size() - q0, 1);
    check("ovr_ferr", n_ferr - f0, 0);
    Rx_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_valid_cleared", Rx_VALID, 0);
    check("ovr_data_held", Rx_DATA, 8'h01);

    // Four back-to-back frames from a transmitter
    q0 = data_q.size();
    o0 = n_ovr;
    for (int i = 0; i < 4; i++) send_frame(8'h56, 1'b1, 0, start);
    wait_bits(2);
    check("loop_rises", data_q.size() - q0, 4);
    for (int i = 0; i < 4; i++)
      if (q0 + i < data_q.size()) check("loop_data", data_q[q0+i], 8'h56);
    check("loop_ovr", n_ovr - o0, 0);

    // Reset in the middle of a frame with a word pending
    Rx_READY = 1'b0;
    send_frame(8'h3C, 1'b1, 0, start);
    wait_bits(1);
    check("mid_pre_valid", Rx_VALID, 1);
    f0 = n_ferr;
    o0 = n_ovr;
    q0 = data_q.size();
    UART_Rx_IN = 1'b0;
    wait_bits(3);
    #2;
    check("mid_pre_busy", Rx_BUSY, 1);
    rstb = 1'b0;
    #1;
    check("mid_rst_valid", Rx_VALID, 0);
    check("mid_rst_data", Rx_DATA, 0);
    check("mid_rst_busy", Rx_BUSY, 0);
    UART_Rx_IN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    Rx_READY = 1'b1;
    wait_bits(8);
    check("mid_no_ferr", n_ferr - f0, 0);
    check("mid_no_ovr", n_ovr - o0, 0);
    check("mid_no_valid", data_q.size() - q0, 0);
    send_frame(8'h96, 1'b1, 0, start);
    wait_bits(2);
    check("post_rst_rises", data_q.size() - q0, 1);
    if (data_q.size() > q0) begin
      check("post_rst_data", data_q[q0], 8'h96);
      check("post_rst_latency", rise_q[q0] - start, LAT);
    end

    check("ferr_ovr_exclusive", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart to the team's UART transmitter; shares the same frame format. Frame is 1 start bit (0), WORD_LENGTH data bits LSB first, no parity, 1 stop bit (1); line idles high. It synchronises the serial input, validates the start bit, samples each bit at mid-bit, and checks the stop bit. It presents each received word on a valid/ready handshake and flags framing and overrun errors. It sits between the board pin and the host-side consumer (FIFO or controller).

Parameters:
CLKS_PER_BIT, `CLKRATE/`BAUD (104 for 1 MHz / 9600), clock cycles per bit period; legal minimum 4.
WORD_LENGTH, `WORD_LENGTH (8), data bits per frame.

Ports:
clk  input  1  system clock.
rstb  input  1  asynchronous active-low reset.
UART_Rx_IN  input  1  serial line, asynchronous to clk, idle high.
Rx_DATA  output  WORD_LENGTH  received word, stable while Rx_VALID=1.
Rx_VALID  output  1  word available; held until accepted.
Rx_READY  input  1  consumer accepts the word when Rx_VALID&&Rx_READY.
Rx_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled 0.
Rx_OVERRUN  output  1  one-cycle pulse: good word dropped because the previous word was not yet accepted.
Rx_BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Rx_DATA=0, Rx_VALID=0, Rx_FRAME_ERR=0, Rx_OVERRUN=0, Rx_BUSY=0.
  - Synchroniser flops=1, FSM=IDLE, all counters=0.
  - Reset mid-frame abandons the frame; no output pulses are produced.
- Input path: 2-flop synchroniser (reset value 1) produces rx_s. All decisions use rx_s, adding 2 cycles of latency.
- Counters:
  - bit_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - data_idx counts 0..WORD_LENGTH-1, width $clog2(WORD_LENGTH).
  - Both clear on every state entry.
- FSM states:
  - IDLE: on rx_s==0 go to START, bit_cnt=0.
  - START: at bit_cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - 0: go to DATA; the sample point is now aligned to mid-bit.
    - 1: glitch; return to IDLE with no error pulse.
  - DATA: at bit_cnt==CLKS_PER_BIT-1, shift rx_s into shift register bit data_idx (LSB first).
    - After data_idx==WORD_LENGTH-1, go to STOP.
  - STOP: at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1: word complete; go to IDLE.
    - 0: pulse Rx_FRAME_ERR, discard the word, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Handles break or stuck-low lines without false starts.
- Output register, evaluated in the cycle after a good stop sample:
  - If Rx_VALID==0, or Rx_VALID&&Rx_READY in that same cycle: load Rx_DATA and set Rx_VALID=1.
  - Otherwise keep the old Rx_DATA and Rx_VALID, and pulse Rx_OVERRUN.
  - Rx_VALID&&Rx_READY with no new word: clear Rx_VALID; Rx_DATA holds its last value.
- Latency:
  - Rx_VALID rises 1 cycle after the stop-bit sample.
  - The stop-bit sample falls at CLKS_PER_BIT/2 + (WORD_LENGTH+1)*CLKS_PER_BIT cycles after rx_s first reads 0.
- Rx_FRAME_ERR and Rx_OVERRUN are never high in the same cycle.
- The next falling edge is accepted in the first IDLE cycle. Back-to-back frames with a single stop bit must be received without loss.

Decomposition:
- Package uart_pkg:
  - Typedef uart_rx_state_e {IDLE, START, DATA, STOP, BREAK}.
  - Localparams CLKS_PER_BIT_DEF=`CLKRATE/`BAUD and WORD_LENGTH_DEF=`WORD_LENGTH, shared with the transmitter.
  - Function clog2_min1 for counter widths.
- One sub-module: uart_sync2. Parameterised-width 2-flop synchroniser with async active-low reset and a configurable reset value, reusable for other async inputs.

Test Plan:
- Idle line, 20 bit periods after rstb release -> Rx_VALID=0, Rx_BUSY=0, no error pulses.
- Frame with data 0x56 at CLKS_PER_BIT=104, Rx_READY=1 -> Rx_DATA=0x56 and Rx_VALID=1, exactly 1 cycle after the stop sample; Rx_VALID drops the next cycle.
- Low glitch of 30 cycles (< 52) on idle line -> returns to IDLE, no Rx_VALID, no Rx_FRAME_ERR.
- Frame 0xA5 with stop bit driven 0, line held low 3 bit periods -> one Rx_FRAME_ERR pulse, no Rx_VALID, Rx_BUSY stays high until the line returns high.
- Back-to-back frames 0x01 then 0xFF with Rx_READY=0 -> Rx_DATA stays 0x01, Rx_VALID=1, one Rx_OVERRUN pulse. Then Rx_READY=1 -> Rx_VALID clears.
- Loopback: UART transmitter output into UART_Rx_IN, four requests of 0x56 -> four Rx_VALID handshakes with Rx_DATA=0x56. rstb pulsed low mid-frame -> all outputs 0 immediately, next full frame received correctly.
